uart_tx_arbiter: RTL and testbench

//  Shares one uart_tx transmitter between N_REQ byte-stream requesters. Arbitrates round-robin
//  at packet boundaries: a granted requester keeps the UART until it sends a byte flagged last.

---
 rtl/uart_tx_arbiter.sv | 165 ++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin packet arbiter that shares one uart_tx between N_REQ byte-stream requesters.
// A granted requester keeps the UART until its last-flagged byte has left the transmitter.
module uart_tx_arbiter #(
   parameter int unsigned N_REQ   = 4,
   parameter int unsigned MAX_GAP = 1024
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [N_REQ-1:0]   req_valid,
   input  logic [8*N_REQ-1:0] req_data,
   input  logic [N_REQ-1:0]   req_last,
   output logic [N_REQ-1:0]   req_ready,
   output logic               tx_start,
   output logic [7:0]         tx_data,
   input  logic               tx_busy,
   output logic [N_REQ-1:0]   grant,
   output logic               gap_abort
);

   localparam int unsigned IW = $clog2(N_REQ);
   localparam int unsigned CW = (MAX_GAP == 0) ? 1 : $clog2(MAX_GAP + 1);
   localparam logic [CW-1:0] GAP_LAST = CW'((MAX_GAP == 0) ? 0 : MAX_GAP - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_SEND,
      S_GAP
   } state_t;

   state_t          state, state_d;
   logic [IW-1:0]   owner, owner_d;
   logic [IW-1:0]   rr_ptr, rr_d;
   logic            last_q, last_d;
   logic [CW-1:0]   gap_cnt, cnt_d;
   logic [N_REQ-1:0] grant_d, ready_d;
   logic            tx_start_d, abort_d;
   logic [7:0]      tx_data_d;

   logic            arb_found;
   logic [IW-1:0]   arb_idx;
   logic            cap;
   logic [IW-1:0]   cap_idx;
   logic [IW-1:0]   owner_next;

   assign owner_next = (owner == IW'(N_REQ - 1)) ? '0 : owner + IW'(1);

   // Search rr_ptr, rr_ptr+1, ... modulo N_REQ for the first valid requester.
   always_comb begin : arb
      int unsigned cand;
      arb_found = 1'b0;
      arb_idx   = '0;
      cand      = 0;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         cand = 32'(rr_ptr) + k;
         if (cand >= N_REQ) cand = cand - N_REQ;
         if (!arb_found && req_valid[IW'(cand)]) begin
            arb_found = 1'b1;
            arb_idx   = IW'(cand);
         end
      end
   end

   always_comb begin
      state_d    = state;
      owner_d    = owner;
      rr_d       = rr_ptr;
      last_d     = last_q;
      cnt_d      = gap_cnt;
      grant_d    = grant;
      tx_start_d = tx_start;
      tx_data_d  = tx_data;
      ready_d    = '0;
      abort_d    = 1'b0;
      cap        = 1'b0;
      cap_idx    = arb_idx;

      case (state)
         S_IDLE: begin
            if (!tx_busy && arb_found) begin
               cap     = 1'b1;
               cap_idx = arb_idx;
            end
         end
         S_START: begin
            if (tx_busy) begin
               tx_start_d = 1'b0;
               state_d    = S_SEND;
            end
         end
         S_SEND: begin
            if (!tx_busy) begin
               if (last_q) begin
                  grant_d = '0;
                  rr_d    = owner_next;
                  state_d = S_IDLE;
               end else begin
                  cnt_d   = '0;
                  state_d = S_GAP;
               end
            end
         end
         S_GAP: begin
            // A byte from the owner beats a timeout landing on the same cycle.
            if (req_valid[owner]) begin
               cap     = 1'b1;
               cap_idx = owner;
            end else begin
               if (gap_cnt != '1) cnt_d = gap_cnt + CW'(1);
               if ((MAX_GAP != 0) && (gap_cnt == GAP_LAST)) begin
                  abort_d = 1'b1;
                  grant_d = '0;
                  rr_d    = owner_next;
                  state_d = S_IDLE;
               end
            end
         end
         default: begin
            state_d    = S_IDLE;
            grant_d    = '0;
            tx_start_d = 1'b0;
            tx_data_d  = '0;
            last_d     = 1'b0;
            cnt_d      = '0;
         end
      endcase

      if (cap) begin
         owner_d    = cap_idx;
         grant_d    = N_REQ'(1) << cap_idx;
         ready_d    = N_REQ'(1) << cap_idx;
         tx_data_d  = req_data[{cap_idx, 3'b000} +: 8];
         last_d     = req_last[cap_idx];
         tx_start_d = 1'b1;
         state_d    = S_START;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         owner     <= '0;
         rr_ptr    <= '0;
         last_q    <= 1'b0;
         gap_cnt   <= '0;
         grant     <= '0;
         req_ready <= '0;
         tx_start  <= 1'b0;
         tx_data   <= '0;
         gap_abort <= 1'b0;
      end else begin
         state     <= state_d;
         owner     <= owner_d;
         rr_ptr    <= rr_d;
         last_q    <= last_d;
         gap_cnt   <= cnt_d;
         grant     <= grant_d;
         req_ready <= ready_d;
         tx_start  <= tx_start_d;
         tx_data   <= tx_data_d;
         gap_abort <= abort_d;
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: a behavioural uart_tx, queue-driven requesters and a
// packet-level model checking ownership, round-robin order, byte order and frames sent.
module tb_uart_tx_arbiter;

   localparam int N   = 4;
   localparam int GAP = 8;

   logic           clk = 1'b0;
   logic           rst;
   logic [N-1:0]   req_valid;
   logic [8*N-1:0] req_data;
   logic [N-1:0]   req_last;
   logic [N-1:0]   req_ready;
   logic           tx_start;
   logic [7:0]     tx_data;
   logic           tx_busy;
   logic [N-1:0]   grant;
   logic           gap_abort;

   int n_checks = 0;
   int n_errors = 0;

   int baud_div   = 16;
   bit long_holds = 0;

   logic [8:0] drv_q [N][$];
   logic [8:0] mdl_q [N][$];
   logic [7:0] exp_tx [$];
   logic [7:0] rx_q [$];
   int         rx_log [$];
   int         win_log [$];
   int         n_abort = 0;
   logic [N-1:0] last_grant_nz = '0;

   uart_tx_arbiter #(.N_REQ(N), .MAX_GAP(GAP)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_last  (req_last),
      .req_ready (req_ready),
      .tx_start  (tx_start),
      .tx_data   (tx_data),
      .tx_busy   (tx_busy),
      .grant     (grant),
      .gap_abort (gap_abort)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic push_byte(input int i, input logic [7:0] b, input logic last);
      drv_q[i].push_back({last, b});
      mdl_q[i].push_back({last, b});
   endtask

   function automatic int rx_at(input int k);
      return (k < rx_log.size()) ? rx_log[k] : -1;
   endfunction

   function automatic int win_at(input int k);
      return (k < win_log.size()) ? win_log[k] : -1;
   endfunction

   function automatic bit drv_empty();
      for (int i = 0; i < N; i++) if (drv_q[i].size() != 0) return 1'b0;
      return 1'b1;
   endfunction

   task automatic wait_idle(input int limit, input string name);
      int n;
      bit idle;
      n = 0;
      idle = 1'b0;
      while (!idle && n < limit) begin
         @(negedge clk);
         n++;
         idle = (req_valid == '0) && !tx_busy && !tx_start && (grant == '0) &&
                (exp_tx.size() == 0) && drv_empty();
      end
      check_eq(name, idle, 1);
      @(negedge clk);
   endtask

   // Behavioural uart_tx: samples start on a clk_en tick, then stays busy for 10 ticks.
   initial begin : uart
      bit s;
      logic [7:0] d, sh;
      int tick, bits;
      tx_busy = 1'b0;
      tick = 0;
      bits = 0;
      sh = '0;
      forever begin
         @(negedge clk);
         s = tx_start;
         d = tx_data;
         @(posedge clk);
         #1;
         if (tick >= baud_div - 1) begin
            tick = 0;
            if (!tx_busy) begin
               if (s) begin
                  tx_busy = 1'b1;
                  sh = d;
                  bits = 10;
               end
            end else begin
               bits--;
               if (bits == 0) begin
                  tx_busy = 1'b0;
                  rx_q.push_back(sh);
               end
            end
         end else begin
            tick++;
         end
      end
   end

   // Requesters hold valid/data/last until their ready pulse, then optionally idle.
   initial begin : drivers
      int hold [N];
      req_valid = '0;
      req_data  = '0;
      req_last  = '0;
      for (int i = 0; i < N; i++) hold[i] = 0;
      forever begin
         @(posedge clk);
         #2;
         for (int i = 0; i < N; i++) begin
            if (req_valid[i] && req_ready[i]) begin
               void'(drv_q[i].pop_front());
               req_valid[i] = 1'b0;
               if (long_holds)
                  hold[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 40) : $urandom_range(0, 3);
               else
                  hold[i] = 0;
            end
            if (!req_valid[i]) begin
               if (hold[i] != 0) begin
                  hold[i]--;
               end else if (drv_q[i].size() != 0) begin
                  req_valid[i]        = 1'b1;
                  req_data[8*i +: 8]  = drv_q[i][0][7:0];
                  req_last[i]         = drv_q[i][0][8];
               end
            end
         end
      end
   end

   // Packet-level model: whoever owns an unfinished packet is the only legal next sender,
   // otherwise the first valid requester at or after the model's round-robin pointer wins.
   initial begin : compare
      int owner, rr, idx, ew, c;
      logic [N-1:0] sv;
      bit bp, sp;
      logic [7:0] dp, b;
      logic [8:0] head, e;
      owner = -1;
      rr = 0;
      sv = '0;
      bp = 1'b0;
      sp = 1'b0;
      dp = '0;
      forever begin
         @(negedge clk);
         while (rx_q.size() != 0) begin
            b = rx_q.pop_front();
            rx_log.push_back(int'(b));
            e = (exp_tx.size() != 0) ? {1'b0, exp_tx.pop_front()} : 9'h1FF;
            check_eq("uart_frame_byte", {1'b0, b}, e);
         end
         if (rst) begin
            owner = -1;
            rr = 0;
         end else begin
            check_eq("grant_onehot0", $onehot0(grant), 1);
            if (grant != '0) last_grant_nz = grant;
            if (tx_start && !sp) check_eq("start_while_busy", bp, 0);
            if (tx_start && sp) check_eq("tx_data_stable", tx_data, dp);
            if (req_ready != '0) begin
               check_eq("ready_onehot", $onehot(req_ready), 1);
               idx = 0;
               for (int i = N - 1; i >= 0; i--) if (req_ready[i]) idx = i;
               check_eq("ready_had_valid", sv[idx], 1);
               check_eq("grant_eq_ready", grant, req_ready);
               check_eq("tx_start_with_ready", tx_start, 1);
               if (owner < 0) begin
                  ew = -1;
                  for (int k = 0; k < N; k++) begin
                     c = (rr + k) % N;
                     if (ew < 0 && sv[c]) ew = c;
                  end
                  check_eq("rr_winner", idx, ew);
               end else begin
                  check_eq("packet_owner", idx, owner);
               end
               win_log.push_back(idx);
               check_eq("byte_pending", mdl_q[idx].size() != 0, 1);
               if (mdl_q[idx].size() != 0) begin
                  head = mdl_q[idx].pop_front();
                  check_eq("captured_byte", tx_data, head[7:0]);
                  exp_tx.push_back(head[7:0]);
                  if (head[8]) begin
                     owner = -1;
                     rr = (idx + 1) % N;
                  end else begin
                     owner = idx;
                  end
               end
            end
            if (gap_abort) begin
               n_abort++;
               check_eq("abort_while_owned", owner >= 0, 1);
               check_eq("abort_grant_clear", grant, 0);
               if (owner >= 0) rr = (owner + 1) % N;
               owner = -1;
            end
         end
         sv = req_valid;
         bp = tx_busy;
         sp = tx_start;
         dp = tx_data;
      end
   end

   initial begin : watchdog
      #900000;
      $display("FAIL watchdog: simulation exceeded its time limit");
      $fatal(1);
   end

   initial begin : main
      int bad, n, wl, rl, ab, total;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check_eq("reset_grant", grant, 0);
      check_eq("reset_tx_start", tx_start, 0);
      check_eq("reset_ready", req_ready, 0);
      check_eq("reset_tx_data", tx_data, 0);
      check_eq("reset_gap_abort", gap_abort, 0);
      @(posedge clk);
      #3 rst = 1'b0;

      // 1: quiet while nothing is valid
      bad = 0;
      repeat (1000) begin
         @(negedge clk);
         if (grant != '0 || tx_start || req_ready != '0 || gap_abort) bad++;
      end
      check_eq("idle_quiet_cycles", bad, 0);

      // 2: two-byte packet from requester 0
      wl = win_log.size();
      rl = rx_log.size();
      push_byte(0, 8'h41, 1'b0);
      push_byte(0, 8'h42, 1'b1);
      wait_idle(5000, "t2_drain");
      check_eq("t2_rx0", rx_at(rl), 32'h41);
      check_eq("t2_rx1", rx_at(rl + 1), 32'h42);
      check_eq("t2_ready_count", win_log.size() - wl, 2);
      check_eq("t2_grant_owner", last_grant_nz, 4'b0001);
      check_eq("t2_grant_released", grant, 0);

      // 3: simultaneous single-byte packets, then all four
      wl = win_log.size();
      push_byte(1, 8'hA1, 1'b1);
      push_byte(2, 8'hA2, 1'b1);
      push_byte(3, 8'hA3, 1'b1);
      wait_idle(8000, "t3a_drain");
      check_eq("t3a_order0", win_at(wl), 1);
      check_eq("t3a_order1", win_at(wl + 1), 2);
      check_eq("t3a_order2", win_at(wl + 2), 3);
      wl = win_log.size();
      for (int i = 0; i < N; i++) push_byte(i, 8'hB0 + 8'(i), 1'b1);
      wait_idle(10000, "t3b_drain");
      for (int i = 0; i < N; i++) check_eq("t3b_order", win_at(wl + i), i);

      // 4: requester 2 waits behind requester 0's three-byte packet
      rl = rx_log.size();
      push_byte(0, 8'hC0, 1'b0);
      push_byte(0, 8'hC1, 1'b0);
      push_byte(0, 8'hC2, 1'b1);
      push_byte(2, 8'hD0, 1'b1);
      wait_idle(10000, "t4_drain");
      check_eq("t4_rx0", rx_at(rl), 32'hC0);
      check_eq("t4_rx1", rx_at(rl + 1), 32'hC1);
      check_eq("t4_rx2", rx_at(rl + 2), 32'hC2);
      check_eq("t4_rx3", rx_at(rl + 3), 32'hD0);

      // 5: owner goes silent mid-packet; grant revoked after MAX_GAP idle cycles
      wl = win_log.size();
      rl = rx_log.size();
      ab = n_abort;
      push_byte(0, 8'h55, 1'b0);
      push_byte(1, 8'h66, 1'b1);
      n = 0;
      while (!req_ready[0] && n < 100) begin @(negedge clk); n++; end
      check_eq("t5_first_ready", req_ready[0], 1);
      n = 0;
      while (!tx_busy && n < 200) begin @(negedge clk); n++; end
      n = 0;
      while (tx_busy && n < 400) begin @(negedge clk); n++; end
      // one edge for SEND to see the UART idle, then MAX_GAP counting edges
      n = 0;
      while (!gap_abort && n < 100) begin n++; @(negedge clk); end
      check_eq("t5_gap_cycles", n, GAP + 1);
      @(negedge clk);
      check_eq("t5_abort_pulse_width", gap_abort, 0);
      wait_idle(5000, "t5_drain");
      check_eq("t5_abort_count", n_abort - ab, 1);
      check_eq("t5_win0", win_at(wl), 0);
      check_eq("t5_win1", win_at(wl + 1), 1);
      check_eq("t5_rx0", rx_at(rl), 32'h55);
      check_eq("t5_rx1", rx_at(rl + 1), 32'h66);

      // 6: reset while a frame is in flight; no new start until the UART drains
      wl = win_log.size();
      rl = rx_log.size();
      push_byte(0, 8'h11, 1'b0);
      push_byte(0, 8'h12, 1'b1);
      n = 0;
      while (!(tx_busy && grant[0]) && n < 400) begin @(negedge clk); n++; end
      check_eq("t6_in_send", tx_busy && grant[0], 1);
      #3 rst = 1'b1;
      #1;
      check_eq("t6_rst_grant", grant, 0);
      check_eq("t6_rst_tx_start", tx_start, 0);
      check_eq("t6_rst_ready", req_ready, 0);
      check_eq("t6_rst_tx_data", tx_data, 0);
      repeat (2) @(negedge clk);
      @(posedge clk);
      #3 rst = 1'b0;
      bad = 0;
      n = 0;
      while (tx_busy && n < 400) begin
         @(negedge clk);
         n++;
         if (tx_start) bad++;
      end
      check_eq("t6_no_start_while_busy", bad, 0);
      wait_idle(5000, "t6_drain");
      check_eq("t6_rx0", rx_at(rl), 32'h11);
      check_eq("t6_rx1", rx_at(rl + 1), 32'h12);
      check_eq("t6_win_after_reset", win_at(wl + 1), 0);

      // 7: randomized packets, random idle between bytes
      baud_div = 2;
      long_holds = 1'b1;
      rl = rx_log.size();
      total = 0;
      repeat (60) begin
         int i, len;
         i = $urandom_range(0, N - 1);
         len = $urandom_range(1, 4);
         for (int k = 0; k < len; k++) push_byte(i, 8'($urandom), (k == len - 1));
         total += len;
         repeat ($urandom_range(0, 30)) @(negedge clk);
      end
      wait_idle(40000, "t7_drain");
      check_eq("t7_frames", rx_log.size() - rl, total);
      for (int i = 0; i < N; i++) check_eq("t7_model_empty", mdl_q[i].size(), 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
